// File: rtl/vec_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one vector ALU array between N_REQ requesters.
// IDLE: grant and accept | EXEC: operands held for ALU_LAT+1 cycles | RESP: result offered until taken
module vec_alu_arbiter #(
    parameter int WIDTH   = 4,
    parameter int N_ALU   = 4,
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*WIDTH*N_ALU-1:0] req_a,
    input  logic [N_REQ*WIDTH*N_ALU-1:0] req_b,
    input  logic [N_REQ*3-1:0]           req_sel,
    output logic [WIDTH*N_ALU-1:0]       alu_a,
    output logic [WIDTH*N_ALU-1:0]       alu_b,
    output logic [2:0]                   alu_select,
    input  logic [N_ALU*8-1:0]           alu_data,
    input  logic [3:0]                   alu_flags,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [IDW-1:0]               rsp_id,
    output logic [N_ALU*8-1:0]           rsp_data,
    output logic [3:0]                   rsp_flags,
    output logic                         busy
);
    localparam int LW = WIDTH * N_ALU;
    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       a_q, a_d;
    logic [LW-1:0]       b_q, b_d;
    logic [2:0]          sel_q, sel_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [N_ALU*8-1:0]  data_q, data_d;
    logic [3:0]          flags_q, flags_d;

    logic                gnt_vld;
    logic [IDW-1:0]      gnt_idx;
    logic [IDW:0]        scan;
    logic [LW-1:0]       gnt_a;
    logic [LW-1:0]       gnt_b;
    logic [2:0]          gnt_sel;

    // First valid requester at or after ptr, wrapping; one extra bit keeps the wrap exact for any N_REQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(N_REQ)) begin
                scan = scan - (IDW+1)'(N_REQ);
            end
            if (!gnt_vld && req_valid[scan[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        gnt_a   = '0;
        gnt_b   = '0;
        gnt_sel = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (gnt_idx == IDW'(r)) begin
                gnt_a   = req_a[r*LW +: LW];
                gnt_b   = req_b[r*LW +: LW];
                gnt_sel = req_sel[r*3 +: 3];
            end
        end
    end

    // Gated by rst so the grant is never visible while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst && (state_q == IDLE) && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        id_d    = id_q;
        data_d  = data_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    sel_d   = gnt_sel;
                    id_d    = gnt_idx;
                    cnt_d   = CW'(ALU_LAT);
                    ptr_d   = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = alu_data;
                    flags_d = alu_flags;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            data_q  <= data_d;
            flags_q <= flags_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = sel_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vec_alu_arbiter.sv
// Bench for vec_alu_arbiter: registered ALU stand-in, transaction-level reference model, directed and random traffic.
module tb_vec_alu_arbiter;
    localparam int WIDTH   = 4;
    localparam int N_ALU   = 4;
    localparam int N_REQ   = 4;
    localparam int ALU_LAT = 1;
    localparam int IDW     = 2;
    localparam int LW      = WIDTH * N_ALU;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*LW-1:0]  req_a;
    logic [N_REQ*LW-1:0]  req_b;
    logic [N_REQ*3-1:0]   req_sel;
    logic [LW-1:0]        alu_a;
    logic [LW-1:0]        alu_b;
    logic [2:0]           alu_select;
    logic [N_ALU*8-1:0]   alu_data;
    logic [3:0]           alu_flags;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [N_ALU*8-1:0]   rsp_data;
    logic [3:0]           rsp_flags;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_alu_arbiter #(
        .WIDTH(WIDTH), .N_ALU(N_ALU), .N_REQ(N_REQ), .ALU_LAT(ALU_LAT), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_data(alu_data), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    // Per-lane ALU behaviour used both by the ALU stand-in and to predict the captured result.
    function automatic logic [N_ALU*8-1:0] alu_fn(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                                 input logic [2:0] sel);
        logic [N_ALU*8-1:0] r;
        int x, y, z;
        r = '0;
        for (int i = 0; i < N_ALU; i++) begin
            x = int'(a[i*WIDTH +: WIDTH]);
            y = int'(b[i*WIDTH +: WIDTH]);
            case (sel)
                3'd0: z = x + y;
                3'd1: z = x - y;
                3'd2: z = x & y;
                3'd3: z = x | y;
                3'd4: z = x ^ y;
                3'd5: z = x * y;
                3'd6: z = (~x) & ((1 << WIDTH) - 1);
                default: z = y;
            endcase
            r[i*8 +: 8] = z[7:0];
        end
        return r;
    endfunction

    function automatic logic [3:0] flags_fn(input logic [LW-1:0] a, input logic [LW-1:0] b);
        int s;
        s = int'(a[WIDTH-1:0]) + int'(b[WIDTH-1:0]);
        return {s >= (1 << WIDTH), a > b, a == b, a < b};
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU stand-in: result registered one cycle after the operands.
    always @(posedge clk) begin
        alu_data  <= alu_fn(alu_a, alu_b, alu_select);
        alu_flags <= flags_fn(alu_a, alu_b);
    end

    typedef struct { int cyc; int id; } acc_t;
    acc_t             acc_q[$];
    int               hs_q[$];
    int               cyc = 0;
    logic [N_REQ-1:0] last_acc = '0;

    // Reference model: one operation in flight, tracked by edges elapsed since its accept.
    bit                 m_busy = 0;
    int                 m_age  = 0;
    int                 m_ptr  = 0;
    int                 m_id   = 0;
    logic [LW-1:0]      m_a    = '0;
    logic [LW-1:0]      m_b    = '0;
    logic [2:0]         m_sel  = '0;
    logic [N_ALU*8-1:0] m_data = '0;
    logic [3:0]         m_flags = '0;

    always @(negedge clk) begin
        logic [N_REQ-1:0] exp_ready;
        logic             exp_rv;
        int               g;
        if (!rst) begin
            check("reset_ctrl_alu", {req_ready, busy, rsp_valid, alu_a, alu_b, alu_select}, '0);
            check("reset_rsp", {rsp_id, rsp_data, rsp_flags}, '0);
            m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0;
            m_a = '0; m_b = '0; m_sel = '0; m_data = '0; m_flags = '0;
            last_acc = '0;
        end else begin
            exp_rv    = m_busy && (m_age == ALU_LAT + 1);
            g         = m_busy ? -1 : rr_pick(req_valid, m_ptr);
            exp_ready = (g >= 0) ? (N_REQ'(1) << g) : '0;
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, exp_rv);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_select", alu_select, m_sel);
            if (m_busy) check("rsp_id", rsp_id, m_id);
            if (exp_rv) begin
                check("rsp_data", rsp_data, m_data);
                check("rsp_flags", rsp_flags, m_flags);
            end
            last_acc = req_ready & req_valid;
            for (int r = 0; r < N_REQ; r++) begin
                if (last_acc[r]) acc_q.push_back('{cyc: cyc, id: r});
            end
            if (rsp_valid && rsp_ready) hs_q.push_back(cyc);
            if (g >= 0) begin
                m_busy  = 1;
                m_age   = 0;
                m_id    = g;
                m_a     = req_a[g*LW +: LW];
                m_b     = req_b[g*LW +: LW];
                m_sel   = req_sel[g*3 +: 3];
                m_data  = alu_fn(m_a, m_b, m_sel);
                m_flags = flags_fn(m_a, m_b);
                m_ptr   = (g + 1) % N_REQ;
            end else if (m_busy) begin
                if (m_age == ALU_LAT + 1) begin
                    if (rsp_ready) m_busy = 0;
                end else begin
                    m_age++;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [2:0] s);
        req_a[r*LW +: LW] = a;
        req_b[r*LW +: LW] = b;
        req_sel[r*3 +: 3] = s;
    endtask

    task automatic rand_req(input int r);
        set_req(r, LW'($urandom), LW'($urandom), 3'($urandom_range(0, 7)));
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        hs_q.delete();
    endtask

    task automatic wait_acc(input int n, input int budget);
        int i = 0;
        while (acc_q.size() < n && i < budget) begin
            step();
            i++;
        end
        if (acc_q.size() < n) check("accept_timeout", acc_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            step();
            i++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    initial begin
        int n;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int exp_wrap[3] = '{2, 0, 1};
        logic [N_REQ-1:0] pend;

        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // single request from requester 2, lane-wise add
        clear_q();
        rsp_ready = 1'b1;
        set_req(2, 16'h1234, 16'h0101, 3'b000);
        req_valid = 4'b0100;
        wait_acc(1, 20);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("single_latency", n, ALU_LAT + 1);
        check("single_id", rsp_id, 2);
        check("single_data", rsp_data, 32'h01030305);
        check("single_flags", rsp_flags, 4'b0100);
        if (acc_q.size() > 0) check("single_accept_id", acc_q[0].id, 2);
        wait_idle(20);

        // all four requesting continuously
        reset_pulse();
        clear_q();
        for (int r = 0; r < N_REQ; r++) rand_req(r);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        wait_acc(5, 60);
        req_valid = '0;
        if (acc_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", acc_q[i].id, exp_rr[i]);
            for (int i = 0; i < 4; i++) check("rr_interval", acc_q[i+1].cyc - acc_q[i].cyc, ALU_LAT + 3);
        end
        wait_idle(20);

        // wrap from ptr=3 and skip idle requesters
        reset_pulse();
        clear_q();
        for (int r = 0; r < N_REQ; r++) rand_req(r);
        req_valid = 4'b0100;
        wait_acc(1, 20);
        req_valid = 4'b0011;
        wait_acc(3, 40);
        req_valid = '0;
        if (acc_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) check("wrap_order", acc_q[i].id, exp_wrap[i]);
        end
        wait_idle(20);

        // backpressure with requester 1 waiting, requester 0 changing payload after accept
        reset_pulse();
        clear_q();
        rsp_ready = 1'b0;
        rand_req(0);
        req_valid = 4'b0001;
        wait_acc(1, 20);
        rand_req(0);
        rand_req(1);
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (10) begin
            step();
            check("bp_ready_low", req_ready, '0);
        end
        rsp_ready = 1'b1;
        wait_acc(2, 20);
        req_valid = '0;
        if (acc_q.size() >= 2 && hs_q.size() >= 1) begin
            check("bp_accept_id", acc_q[1].id, 1);
            check("bp_accept_after_hs", acc_q[1].cyc - hs_q[0], 1);
        end
        wait_idle(20);

        // reset during EXEC aborts the operation
        clear_q();
        rand_req(3);
        req_valid = 4'b1000;
        wait_acc(1, 20);
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_alu_a", alu_a, '0);
        step();
        rst = 1'b1;
        repeat (8) step();
        check("abort_no_rsp", hs_q.size(), 0);

        // random traffic
        reset_pulse();
        clear_q();
        pend = '0;
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (pend[r] && last_acc[r]) pend[r] = 1'b0;
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    rand_req(r);
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(50);
        check("rand_accepts_seen", acc_q.size() > 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
